// File: rtl/led_pkg.sv
// Shared constants for the LED PWM fader: channel count, channel map and fade state encoding.
package led_pkg;

    localparam int LED_CH   = 4;
    localparam int CH_RUN0  = 0;
    localparam int CH_RUN1  = 1;
    localparam int CH_RUN2  = 2;
    localparam int CH_FLASH = 3;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RISE = 2'b01,
        ST_ON   = 2'b10,
        ST_FALL = 2'b11
    } led_state_t;

endpackage

// File: rtl/led_fade_channel.sv
// One fader channel: brightness level ramp, fade state, duty mapping and PWM compare.
// Optional square-law duty curve when LED_PWM_GAMMA_EN is defined.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                fade_tick,
    input  logic                tgt,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_MIN = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] level_r;
    logic [PWM_BITS-1:0] level_nxt_s;
    logic [PWM_BITS-1:0] duty_s;
    led_state_t          state_r;
    led_state_t          state_nxt_s;
    logic                led_r;
    logic                led_nxt_s;

    // Level moves one step toward the target, only on a fade tick.
    always_comb begin
        level_nxt_s = level_r;
        if (fade_tick && tgt && (level_r != LVL_MAX)) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (fade_tick && !tgt && (level_r != LVL_MIN)) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Level and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= LVL_MIN;
            state_r <= ST_OFF;
        end else begin
            level_r <= level_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a reversal keeps the current level and just flips direction.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (fade_tick && tgt) begin
                    state_nxt_s = (level_nxt_s == LVL_MAX) ? ST_ON : ST_RISE;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_RISE: begin
                if (level_nxt_s == LVL_MAX) begin
                    state_nxt_s = ST_ON;
                end else if (fade_tick && !tgt) begin
                    state_nxt_s = (level_nxt_s == LVL_MIN) ? ST_OFF : ST_FALL;
                end else begin
                    state_nxt_s = ST_RISE;
                end
            end
            ST_ON: begin
                if (fade_tick && !tgt) begin
                    state_nxt_s = (level_nxt_s == LVL_MIN) ? ST_OFF : ST_FALL;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_FALL: begin
                if (level_nxt_s == LVL_MIN) begin
                    state_nxt_s = ST_OFF;
                end else if (fade_tick && tgt) begin
                    state_nxt_s = (level_nxt_s == LVL_MAX) ? ST_ON : ST_RISE;
                end else begin
                    state_nxt_s = ST_FALL;
                end
            end
            default: state_nxt_s = ST_OFF;
        endcase
    end

`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq_s;
    assign level_sq_s = {{PWM_BITS{1'b0}}, level_r} * {{PWM_BITS{1'b0}}, level_r};
    assign duty_s     = PWM_BITS'(level_sq_s >> PWM_BITS);
`else
    assign duty_s     = level_r;
`endif

    // Output decode: full level is a steady 1, zero level a steady 0, else compare.
    always_comb begin
        led_nxt_s = 1'b0;
        case (state_r)
            ST_ON:  led_nxt_s = 1'b1;
            ST_OFF: led_nxt_s = 1'b0;
            default: begin
                if (level_r == LVL_MAX) begin
                    led_nxt_s = 1'b1;
                end else if (level_r == LVL_MIN) begin
                    led_nxt_s = 1'b0;
                end else begin
                    led_nxt_s = (pwm_cnt < duty_s);
                end
            end
        endcase
    end

    // Registered pad drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 1'b0;
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign led = led_r;

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader: turns on/off pattern lines into linearly faded PWM pad drive.
// Define LED_PWM_GAMMA_EN for a square-law duty curve in every channel.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS = 4,
    parameter int FADE_DIV = 1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [2:0] Run_LED_in,
    input  logic       Flash_LED_in,
    output logic [3:0] LED_out
);

    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};

    logic [LED_CH-1:0]   tgt_in_s;
    logic [LED_CH-1:0]   tgt_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [DIV_W-1:0]    fade_div_cnt_r;
    logic                period_end_s;
    logic                fade_tick_s;
    logic [LED_CH-1:0]   led_s;

    // Map the pattern lines onto channel indices.
    always_comb begin
        tgt_in_s           = {LED_CH{1'b0}};
        tgt_in_s[CH_RUN0]  = Run_LED_in[0];
        tgt_in_s[CH_RUN1]  = Run_LED_in[1];
        tgt_in_s[CH_RUN2]  = Run_LED_in[2];
        tgt_in_s[CH_FLASH] = Flash_LED_in;
    end

    // Single input register; source shares this clock.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tgt_r <= {LED_CH{1'b0}};
        end else begin
            tgt_r <= tgt_in_s;
        end
    end

    assign period_end_s = (pwm_cnt_r == PWM_MAX);
    assign fade_tick_s  = period_end_s && (fade_div_cnt_r == DIV_LAST);

    // Free-running PWM counter, wraps naturally at max.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end
    end

    // Period divider producing the fade tick.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fade_div_cnt_r <= {DIV_W{1'b0}};
        end else if (fade_tick_s) begin
            fade_div_cnt_r <= {DIV_W{1'b0}};
        end else if (period_end_s) begin
            fade_div_cnt_r <= fade_div_cnt_r + DIV_W'(1);
        end else begin
            fade_div_cnt_r <= fade_div_cnt_r;
        end
    end

    for (genvar ch = 0; ch < LED_CH; ch++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (CLK),
            .rst_n     (RSTn),
            .pwm_cnt   (pwm_cnt_r),
            .fade_tick (fade_tick_s),
            .tgt       (tgt_r[ch]),
            .led       (led_s[ch])
        );
    end

    assign LED_out = led_s;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader at PWM_BITS=4, FADE_DIV=1; counts high cycles per PWM period.
module tb_led_pwm_fader;

    logic       CLK;
    logic       RSTn;
    logic [2:0] Run_LED_in;
    logic       Flash_LED_in;
    logic [3:0] LED_out;

    int total;
    int bad;
    int n;

    led_pwm_fader #(
        .PWM_BITS (4),
        .FADE_DIV (1)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .Run_LED_in   (Run_LED_in),
        .Flash_LED_in (Flash_LED_in),
        .LED_out      (LED_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // High cycles expected in one 16-cycle period for a given level.
    function automatic int exp_hi(input int lvl);
        int d;
        if (lvl == 15) return 16;
`ifdef LED_PWM_GAMMA_EN
        d = (lvl * lvl) >> 4;
`else
        d = lvl;
`endif
        return d;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        n++;
    endtask

    // Sixteen samples aligned to one PWM period; arguments are expected levels.
    task automatic measure(input string tag, input int l0, input int l1, input int l2, input int l3);
        int hi[4];
        for (int k = 0; k < 4; k++) hi[k] = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            for (int k = 0; k < 4; k++) hi[k] += int'(LED_out[k]);
        end
        chk({tag, "_ch0"}, hi[0], exp_hi(l0));
        chk({tag, "_ch1"}, hi[1], exp_hi(l1));
        chk({tag, "_ch2"}, hi[2], exp_hi(l2));
        chk({tag, "_ch3"}, hi[3], exp_hi(l3));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        n            = 0;
        RSTn         = 1'b0;
        Run_LED_in   = 3'b111;
        Flash_LED_in = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_hold", int'(LED_out), 0);
        end

        Run_LED_in   = 3'b001;
        Flash_LED_in = 1'b0;
        RSTn         = 1'b1;
        n            = 0;

        measure("rise_m0", 0, 0, 0, 0);
        for (int m = 1; m <= 15; m++) begin
            measure($sformatf("rise_m%0d", m), m, 0, 0, 0);
        end

        Run_LED_in = 3'b000;
        measure("fall_m16", 15, 0, 0, 0);
        for (int m = 17; m <= 31; m++) begin
            measure($sformatf("fall_m%0d", m), 31 - m, 0, 0, 0);
        end

        Flash_LED_in = 1'b1;
        for (int m = 32; m <= 36; m++) begin
            measure($sformatf("rev_up_m%0d", m), 0, 0, 0, m - 32);
        end
        Flash_LED_in = 1'b0;
        for (int m = 37; m <= 42; m++) begin
            measure($sformatf("rev_dn_m%0d", m), 0, 0, 0, 42 - m);
        end

        for (int i = 0; i < 2; i++) begin
            step();
            chk("pulse_pre", int'(LED_out[1]), 0);
        end
        Run_LED_in = 3'b010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pulse_on", int'(LED_out[1]), 0);
        end
        Run_LED_in = 3'b000;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("pulse_post", int'(LED_out[1]), 0);
        end
        measure("pulse_m44", 0, 0, 0, 0);

        Run_LED_in = 3'b001;
        measure("rst_ramp_m45", 0, 0, 0, 0);
        for (int m = 46; m <= 52; m++) begin
            measure($sformatf("rst_ramp_m%0d", m), m - 45, 0, 0, 0);
        end
        step();
        step();
        chk("level8_on", int'(LED_out), 1);
        RSTn = 1'b0;
        #1;
        chk("async_rst", int'(LED_out), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_low", int'(LED_out), 0);
        end
        RSTn = 1'b1;
        n    = 0;
        measure("restart_m0", 0, 0, 0, 0);
        measure("restart_m1", 1, 0, 0, 0);
        measure("restart_m2", 2, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
